// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus the IF/ID pipeline register.
//
// Owns the architectural fetch PC and issues word reads to instruction memory.
// At most one imem request is outstanding at a time. A one-entry skid buffer
// catches a response that returns while decode is stalled. Decode's branch,
// jump and jr redirects are applied here.
//
// Build option: define BRANCH_DELAY_SLOT_EN to keep the MIPS delay-slot
// instruction on a redirect. When it is undefined, everything younger than the
// redirecting instruction is squashed.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   imem_req/addr   fetch request and word-aligned address
//   imem_gnt        request accepted this cycle
//   imem_rvalid     in-order response valid; imem_rdata carries the word
//   stall           decode stall; IF/ID holds
//   jump_branch     taken conditional branch in decode
//   jump_target     J-type jump in decode
//   jump_reg        register jump in decode; jr_pc is its target
//   pc_id/instr_id  IF/ID contents; instr_valid_id marks a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        instr_valid_id
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StFull = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        kill_q, kill_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        instr_valid_q, instr_valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
`endif

  logic [31:0] pc_id_plus4;
  logic [31:0] br_offset;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        granted;
  logic        resp_live;
  logic        resp_keep;
  logic        rst_kill;

  // While kill is set a squashed response is still in flight; issuing another
  // request would break the one-outstanding rule, so the request is gated.
  assign imem_req  = (state_q == StReq) & ~kill_q;
  assign imem_addr = fetch_pc_q;
  assign granted   = imem_req & imem_gnt;
  assign resp_live = imem_rvalid & ~kill_q;

  assign redirect    = (jump_branch | jump_target | jump_reg) & instr_valid_q & ~stall;
  assign pc_id_plus4 = pc_id_q + 32'd4;
  assign br_offset   = {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};

  always_comb begin
    if (jump_reg) begin
      redirect_target = jr_pc;
    end else if (jump_target) begin
      redirect_target = {pc_id_plus4[31:28], instr_id_q[25:0], 2'b00};
    end else begin
      redirect_target = pc_id_plus4 + br_offset;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // The delay slot is the next instruction in order, so a live response is kept.
  assign resp_keep = resp_live;
`else
  assign resp_keep = resp_live & ~redirect;
`endif

  // A reset that lands while a response is owed must still swallow it.
  assign rst_kill = ((kill_q | (state_q == StWait)) & ~imem_rvalid) | granted;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    pc_id_d       = pc_id_q;
    instr_id_d    = instr_id_q;
    instr_valid_d = instr_valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
`endif

    if (imem_rvalid && kill_q) begin
      kill_d = 1'b0;
    end

    // IF/ID and skid buffer. The skid entry is always older than any response.
    if (!stall) begin
      if (skid_valid_q) begin
        pc_id_d       = skid_pc_q;
        instr_id_d    = skid_instr_q;
        instr_valid_d = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (resp_keep) begin
        pc_id_d       = inflight_pc_q;
        instr_id_d    = imem_rdata;
        instr_valid_d = 1'b1;
      end else begin
        instr_id_d    = NOP_INSTR;
        instr_valid_d = 1'b0;
      end
    end else if (resp_keep) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = inflight_pc_q;
      skid_instr_d = imem_rdata;
    end

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (granted) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          state_d = skid_valid_d ? StFull : StReq;
        end
      end
      StFull: begin
        if (!skid_valid_d) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef BRANCH_DELAY_SLOT_EN
    // Delay slot granted: the latched target becomes the next fetch address.
    if (granted && pend_valid_q) begin
      fetch_pc_d   = pend_target_q;
      pend_valid_d = 1'b0;
    end

    if (redirect) begin
      if (state_q == StReq && !granted) begin
        // Delay slot not yet requested; keep fetching it, remember the target.
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_target;
      end else begin
        // Delay slot is in the skid buffer, in flight, or granted right now.
        fetch_pc_d = redirect_target;
      end
    end
`else
    if (redirect) begin
      pc_id_d       = pc_id_q;
      instr_id_d    = NOP_INSTR;
      instr_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
      fetch_pc_d    = redirect_target;
      state_d       = StReq;
      if ((state_q == StWait && !imem_rvalid) || granted) begin
        kill_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      kill_q        <= rst_kill;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= NOP_INSTR;
      pc_id_q       <= 32'h0;
      instr_id_q    <= NOP_INSTR;
      instr_valid_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      pc_id_q       <= pc_id_d;
      instr_id_q    <= instr_id_d;
      instr_valid_q <= instr_valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
`endif
    end
  end

  assign pc_id          = pc_id_q;
  assign instr_id       = instr_id_q;
  assign instr_valid_id = instr_valid_q;

endmodule
